// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stream_demux_pkg
// Purpose : Shared constants and channel encoding for the 16-bit stream demux.
// Revision: 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int FIFO_DEPTH    = 2;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } channel_e;

endpackage : stream_demux_pkg
`default_nettype wire

// File: rtl/demux_fifo_2.sv
`default_nettype none
// ============================================================================
// Module  : demux_fifo_2
// Purpose : Two-entry synchronous FIFO with registered occupancy and zeroed head.
// Revision: 1.0 - initial release
// ============================================================================
module demux_fifo_2
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam logic [1:0] C_CNT_FULL = 2'd2;

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;

  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == C_CNT_FULL);
  assign empty  = (r_count == 2'd0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  // Head reads as zero when nothing is stored so consumers never see stale data.
  assign head   = empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= push_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : demux_fifo_2
`default_nettype wire

// File: rtl/stream_demux_16.sv
`default_nettype none
// ============================================================================
// Module  : stream_demux_16
// Purpose : One-to-two valid/ready stream demux with per-channel beat counters.
// Revision: 1.0 - initial release
// ============================================================================
module stream_demux_16
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             out_b_valid,
  input  logic             out_b_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  generate
    if (DEPTH != FIFO_DEPTH) begin : g_depth_check
      $error("stream_demux_16: only DEPTH == 2 is supported");
    end
  endgenerate

  channel_e         w_sel_ch;
  logic             w_full_a;
  logic             w_full_b;
  logic             w_empty_a;
  logic             w_empty_b;
  logic             w_push;
  logic             w_push_a;
  logic             w_push_b;
  logic             w_pop_a;
  logic             w_pop_b;
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;

  assign w_sel_ch = channel_e'(in_sel);

  // Ready looks only at stored occupancy, so a full channel stays blocked even
  // while its consumer drains it this cycle.
  assign in_ready = rst_n && ((w_sel_ch == CH_B) ? !w_full_b : !w_full_a);

  assign w_push   = in_valid && in_ready;
  assign w_push_a = w_push && (w_sel_ch == CH_A);
  assign w_push_b = w_push && (w_sel_ch == CH_B);

  assign out_a_valid = !w_empty_a;
  assign out_b_valid = !w_empty_b;
  assign w_pop_a     = out_a_valid && out_a_ready;
  assign w_pop_b     = out_b_valid && out_b_ready;

  demux_fifo_2 #(
    .WIDTH (WIDTH)
  ) u_fifo_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push_a),
    .push_data (in_data),
    .pop       (w_pop_a),
    .full      (w_full_a),
    .empty     (w_empty_a),
    .head      (out_a_data)
  );

  demux_fifo_2 #(
    .WIDTH (WIDTH)
  ) u_fifo_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push_b),
    .push_data (in_data),
    .pop       (w_pop_b),
    .full      (w_full_b),
    .empty     (w_empty_b),
    .head      (out_b_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (w_pop_a) begin
        r_cnt_a <= r_cnt_a + CNT_W'(1);
      end
      if (w_pop_b) begin
        r_cnt_b <= r_cnt_b + CNT_W'(1);
      end
    end
  end

  assign cnt_a = r_cnt_a;
  assign cnt_b = r_cnt_b;

endmodule : stream_demux_16
`default_nettype wire

// File: tb/tb_stream_demux_16.sv
`default_nettype none
// ============================================================================
// Module  : tb_stream_demux_16
// Purpose : Self-checking bench for stream_demux_16 against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_stream_demux_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_a_data;
  logic        out_a_valid;
  logic        out_a_ready;
  logic [15:0] out_b_data;
  logic        out_b_valid;
  logic        out_b_ready;
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;

  int vectors;
  int miscompares;

  // Reference model: one queue per channel plus delivered-word counts.
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  logic [15:0] m_cnt_a;
  logic [15:0] m_cnt_b;

  stream_demux_16 #(
    .WIDTH (16),
    .DEPTH (2),
    .CNT_W (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_a_data  (out_a_data),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_b_data  (out_b_data),
    .out_b_valid (out_b_valid),
    .out_b_ready (out_b_ready),
    .cnt_a       (cnt_a),
    .cnt_b       (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic rn, input logic v, input logic s, input logic [15:0] d,
                       input logic ra, input logic rb);
    @(negedge clk);
    rst_n       = rn;
    in_valid    = v;
    in_sel      = s;
    in_data     = d;
    out_a_ready = ra;
    out_b_ready = rb;
    #1;
  endtask

  // Advance one rising edge and apply the same transfer rules to the model.
  task automatic commit();
    logic push_ok;
    logic pop_a;
    logic pop_b;
    push_ok = rst_n && in_valid && (in_sel ? (q_b.size() < 2) : (q_a.size() < 2));
    pop_a   = (q_a.size() != 0) && out_a_ready;
    pop_b   = (q_b.size() != 0) && out_b_ready;
    @(posedge clk);
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
      m_cnt_a = 16'h0;
      m_cnt_b = 16'h0;
    end else begin
      if (pop_a) begin
        void'(q_a.pop_front());
        m_cnt_a = m_cnt_a + 16'h1;
      end
      if (pop_b) begin
        void'(q_b.pop_front());
        m_cnt_b = m_cnt_b + 16'h1;
      end
      if (push_ok) begin
        if (in_sel) q_b.push_back(in_data);
        else        q_a.push_back(in_data);
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b0, 16'h5555, 1'b1, 1'b1);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready_sel0: got %b expected 0", in_ready);
    end
    commit();
    drive(1'b0, 1'b1, 1'b1, 16'h5555, 1'b1, 1'b1);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready_sel1: got %b expected 0", in_ready);
    end
    commit();
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    vectors++;
    if ({out_a_valid, out_b_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_valid: got a=%b b=%b expected 0 0", out_a_valid, out_b_valid);
    end
    vectors++;
    if ({cnt_a, cnt_b} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_counters: got a=%h b=%h expected 0000 0000", cnt_a, cnt_b);
    end
    vectors++;
    if ({out_a_data, out_b_data} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got a=%h b=%h expected 0000 0000", out_a_data, out_b_data);
    end
    commit();
  endtask

  task automatic test_basic_routing();
    drive(1'b1, 1'b1, 1'b0, 16'hABCD, 1'b1, 1'b1);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_in_ready: got %b expected 1", in_ready);
    end
    commit();
    drive(1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);
    vectors++;
    if (out_a_valid !== 1'b1 || out_a_data !== 16'hABCD) begin
      miscompares++;
      $display("FAIL basic_a_head: got v=%b d=%h expected v=1 d=abcd", out_a_valid, out_a_data);
    end
    vectors++;
    if (out_b_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_b_idle: got v=%b expected 0", out_b_valid);
    end
    commit();
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    vectors++;
    if (out_b_valid !== 1'b1 || out_b_data !== 16'h1234) begin
      miscompares++;
      $display("FAIL basic_b_head: got v=%b d=%h expected v=1 d=1234", out_b_valid, out_b_data);
    end
    vectors++;
    if (cnt_a !== 16'd1 || out_a_valid !== 1'b0 || out_a_data !== 16'h0) begin
      miscompares++;
      $display("FAIL basic_a_popped: got cnt=%h v=%b d=%h expected cnt=0001 v=0 d=0000",
               cnt_a, out_a_valid, out_a_data);
    end
    commit();
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    vectors++;
    if (cnt_b !== 16'd1) begin
      miscompares++;
      $display("FAIL basic_cnt_b: got %h expected 0001", cnt_b);
    end
    commit();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b1);
    commit();
    drive(1'b1, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b1);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_second_accept: got %b expected 1", in_ready);
    end
    commit();
    drive(1'b1, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b1);
    vectors++;
    if (in_ready !== 1'b0 || out_a_data !== 16'h0001) begin
      miscompares++;
      $display("FAIL bp_full: got ready=%b d=%h expected ready=0 d=0001", in_ready, out_a_data);
    end
    in_sel = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_other_channel_ready: got %b expected 1", in_ready);
    end
    in_sel = 1'b0;
    #1;
    commit();
    drive(1'b1, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b1);
    vectors++;
    if (in_ready !== 1'b0 || out_a_data !== 16'h0001) begin
      miscompares++;
      $display("FAIL bp_drain_while_full: got ready=%b d=%h expected ready=0 d=0001",
               in_ready, out_a_data);
    end
    commit();
    drive(1'b1, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b1);
    vectors++;
    if (in_ready !== 1'b1 || out_a_data !== 16'h0002) begin
      miscompares++;
      $display("FAIL bp_second_pop: got ready=%b d=%h expected ready=1 d=0002", in_ready, out_a_data);
    end
    commit();
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    vectors++;
    if (out_a_valid !== 1'b1 || out_a_data !== 16'h0003) begin
      miscompares++;
      $display("FAIL bp_third_word: got v=%b d=%h expected v=1 d=0003", out_a_valid, out_a_data);
    end
    commit();
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    vectors++;
    if (cnt_a !== 16'd4 || out_a_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_cnt_a: got cnt=%h v=%b expected cnt=0004 v=0", cnt_a, out_a_valid);
    end
    commit();
  endtask

  task automatic test_simul_push_pop();
    drive(1'b1, 1'b1, 1'b1, 16'h00AA, 1'b1, 1'b0);
    commit();
    drive(1'b1, 1'b1, 1'b1, 16'h00BB, 1'b1, 1'b1);
    vectors++;
    if (in_ready !== 1'b1 || out_b_data !== 16'h00AA) begin
      miscompares++;
      $display("FAIL simul_pre: got ready=%b d=%h expected ready=1 d=00aa", in_ready, out_b_data);
    end
    commit();
    drive(1'b1, 1'b1, 1'b1, 16'h00CC, 1'b1, 1'b0);
    vectors++;
    if (out_b_valid !== 1'b1 || out_b_data !== 16'h00BB || cnt_b !== 16'd2) begin
      miscompares++;
      $display("FAIL simul_post: got v=%b d=%h cnt=%h expected v=1 d=00bb cnt=0002",
               out_b_valid, out_b_data, cnt_b);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_occ_one: got ready=%b expected 1", in_ready);
    end
    commit();
    drive(1'b1, 1'b1, 1'b1, 16'h00DD, 1'b1, 1'b0);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_occ_two: got ready=%b expected 0", in_ready);
    end
    commit();
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    commit();
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    commit();
  endtask

  task automatic test_counter_wrap();
    int guard;
    guard = 0;
    while (m_cnt_a != 16'hFFFF && guard < 70000) begin
      drive(1'b1, 1'b1, 1'b0, 16'($urandom), 1'b1, 1'b0);
      commit();
      guard++;
    end
    vectors++;
    if (guard >= 70000) begin
      miscompares++;
      $display("FAIL wrap_budget: got %0d cycles expected fewer than 70000", guard);
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    vectors++;
    if (cnt_a !== 16'hFFFF || out_a_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_pre: got cnt=%h v=%b expected cnt=ffff v=1", cnt_a, out_a_valid);
    end
    commit();
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    vectors++;
    if (cnt_a !== 16'h0000) begin
      miscompares++;
      $display("FAIL wrap_post: got cnt=%h expected 0000", cnt_a);
    end
    commit();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, i[0], 16'($urandom), 1'b0, 1'b0);
      commit();
    end
    drive(1'b0, 1'b1, 1'b0, 16'h1111, 1'b1, 1'b1);
    vectors++;
    if (out_a_valid !== 1'b1 || out_b_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_filled: got va=%b vb=%b ready=%b expected 1 1 0",
               out_a_valid, out_b_valid, in_ready);
    end
    commit();
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    vectors++;
    if ({out_a_valid, out_b_valid} !== 2'b00 || {cnt_a, cnt_b} !== 32'h0 ||
        {out_a_data, out_b_data} !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_cleared: got va=%b vb=%b ca=%h cb=%h da=%h db=%h expected all 0",
               out_a_valid, out_b_valid, cnt_a, cnt_b, out_a_data, out_b_data);
    end
    commit();
  endtask

  task automatic test_random_soak();
    logic        exp_ready;
    logic [15:0] exp_ad;
    logic [15:0] exp_bd;
    for (int i = 0; i < 1000; i++) begin
      drive(($urandom_range(0, 99) != 0), 1'($urandom), 1'($urandom), 16'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      exp_ready = rst_n && (in_sel ? (q_b.size() < 2) : (q_a.size() < 2));
      exp_ad    = (q_a.size() != 0) ? q_a[0] : 16'h0;
      exp_bd    = (q_b.size() != 0) ? q_b[0] : 16'h0;
      vectors++;
      if (in_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL soak_ready cycle %0d: got %b expected %b", i, in_ready, exp_ready);
      end
      vectors++;
      if (out_a_valid !== (q_a.size() != 0) || out_a_data !== exp_ad) begin
        miscompares++;
        $display("FAIL soak_a cycle %0d: got v=%b d=%h expected v=%b d=%h",
                 i, out_a_valid, out_a_data, (q_a.size() != 0), exp_ad);
      end
      vectors++;
      if (out_b_valid !== (q_b.size() != 0) || out_b_data !== exp_bd) begin
        miscompares++;
        $display("FAIL soak_b cycle %0d: got v=%b d=%h expected v=%b d=%h",
                 i, out_b_valid, out_b_data, (q_b.size() != 0), exp_bd);
      end
      vectors++;
      if (cnt_a !== m_cnt_a || cnt_b !== m_cnt_b) begin
        miscompares++;
        $display("FAIL soak_cnt cycle %0d: got a=%h b=%h expected a=%h b=%h",
                 i, cnt_a, cnt_b, m_cnt_a, m_cnt_b);
      end
      commit();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_cnt_a     = 16'h0;
    m_cnt_b     = 16'h0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_sel      = 1'b0;
    in_data     = 16'h0;
    out_a_ready = 1'b0;
    out_b_ready = 1'b0;

    test_reset();
    test_basic_routing();
    test_backpressure();
    test_simul_push_pop();
    test_counter_wrap();
    test_mid_reset();
    test_random_soak();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_stream_demux_16
`default_nettype wire

// File: doc/stream_demux_16.md
Name: stream_demux_16

Overview:
- 16-bit one-to-two stream demultiplexer with valid/ready handshakes. It is the routing counterpart of mux_16.
- Each accepted input word is steered by `sel` into one of two independent 2-entry output FIFOs, channel A or channel B.
- It sits between a single word producer (CPU/bus master side) and two consumers (e.g. RAM-side and screen-side writers).
- It keeps per-channel beat counters for debug.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 2, entries per channel FIFO. Only the value 2 is supported; any other value is an elaboration error.
- CNT_W, 16, width of each beat counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_data  in  WIDTH  input word.
- in_sel  in  1  routing select: 0 = channel A, 1 = channel B. Qualified by in_valid.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block can accept a word for the currently selected channel.
- out_a_data  out  WIDTH  head word of channel A.
- out_a_valid  out  1  channel A FIFO not empty.
- out_a_ready  in  1  consumer A accepts the head word.
- out_b_data  out  WIDTH  head word of channel B.
- out_b_valid  out  1  channel B FIFO not empty.
- out_b_ready  in  1  consumer B accepts the head word.
- cnt_a  out  CNT_W  words delivered on channel A (pops), modulo 2^CNT_W.
- cnt_b  out  CNT_W  words delivered on channel B (pops), modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - Both FIFOs are emptied and both read/write pointers return to 0.
  - out_*_valid=0, out_*_data=0, cnt_a=cnt_b=0.
  - in_ready=0 combinationally while rst_n=0.
  - Reset mid-transfer discards all stored words; no pop is counted in the reset cycle.
- Ready:
  - in_ready = rst_n && (in_sel ? !full_b : !full_a), where full_x = (occupancy_x == 2).
  - in_ready depends only on registered occupancy, never on out_x_ready. A full channel cannot accept a word even if it is being drained in the same cycle.
- Push: occurs when in_valid && in_ready. in_data is written into the FIFO selected by in_sel at that edge.
  - in_sel is don't-care when in_valid=0.
- Pop: occurs on channel x when out_x_valid && out_x_ready. The head word advances and cnt_x increments by 1, wrapping from 2^CNT_W-1 to 0.
- Latency: a word pushed at edge N is visible on out_x_data with out_x_valid=1 after edge N (from cycle N+1). There is no combinational path from in_* to out_*.
- Ordering: FIFO order is preserved within each channel. There is no ordering relationship between channels.
- out_x_data holds the head word while out_x_valid=1 and no pop occurs (stable under backpressure).
- out_x_data is 0 whenever out_x_valid=0.
- Simultaneous push and pop on the same channel:
  - occupancy 1 → stays 1; the new word becomes head next cycle.
  - occupancy 0 → push only.
  - occupancy 2 → pop only (push is blocked by in_ready=0).
- Pushing to one channel and popping the other in the same cycle is independent.
- Occupancy per channel is 0..2. Pointers are 1 bit each and wrap naturally.
- Blocked-channel stall: when the selected channel is full, in_ready=0. The producer must hold in_data and in_sel until the push is accepted (head-of-line blocking is accepted behaviour).

Decomposition:
- Shared package stream_demux_pkg holds:
  - WIDTH_DEFAULT=16
  - the channel enum: CH_A=1'b0, CH_B=1'b1
  - FIFO_DEPTH=2
- Sub-module demux_fifo_2 is a 2-entry synchronous FIFO with push/pop/full/empty/head. It is instantiated twice.
- Counters and ready logic live in the top level.

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles with in_valid=1 → in_ready=0, out_a_valid=out_b_valid=0, cnt_a=cnt_b=0, both out data=0.
- Basic routing: push 16'hABCD sel=0, then 16'h1234 sel=1, both consumers ready=1 → out_a_data=16'hABCD valid one cycle after its push; out_b_data=16'h1234 valid one cycle after its push; cnt_a=1, cnt_b=1.
- Backpressure and full: out_a_ready=0, push 16'h0001, 16'h0002, 16'h0003 to A → first two accepted, in_ready=0 on the third, out_a_data stays 16'h0001. Meanwhile a push with sel=1 has in_ready=1. Release out_a_ready → pops 0001 then 0002, and 0003 is accepted once occupancy<2.
- Simultaneous push and pop at occupancy 1 on B: data 16'h00AA stored, then push 16'h00BB with out_b_ready=1 → occupancy remains 1; next cycle out_b_data=16'h00BB; cnt_b increments by 1.
- Counter wrap: force 65536 pops on A (or preset via a bench hook and pop once from 16'hFFFF) → cnt_a goes 16'hFFFF→16'h0000.
- Mid-operation reset plus random soak: fill both channels, assert rst_n=0 for one edge → all valid=0 and counters=0. Then 1000 cycles of $random data/sel/valid/ready checked against a scoreboard of two reference queues.
